// File: rtl/counter_edge_unit.sv
// Rising-edge detector feeding a modulo-M event counter and a saturating score counter
// that advances once per event-counter wrap.
module counter_edge_unit #(
  parameter int unsigned M    = 40,
  parameter int unsigned N    = 6,
  parameter int unsigned MAX  = 7,
  parameter int unsigned NMAX = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sinal,
  input  logic            conta,
  input  logic            zera_s,
  output logic            pulso,
  output logic [N-1:0]    Q,
  output logic            fim,
  output logic            meio,
  output logic [NMAX-1:0] Q_max,
  output logic            fim_max,
  output logic            meio_max
);

  localparam logic [N-1:0]    QLast = N'(M - 1);
  localparam logic [N-1:0]    QHalf = N'(M / 2);
  localparam logic [NMAX-1:0] SLast = NMAX'(MAX);
  localparam logic [NMAX-1:0] SHalf = NMAX'(MAX / 2);

  logic            prev_q;
  logic [N-1:0]    cnt_q, cnt_d;
  logic [NMAX-1:0] score_q, score_d;
  logic            inc;

  always_comb begin
    pulso   = sinal & ~prev_q;
    inc     = pulso & conta & ~zera_s;
    cnt_d   = cnt_q;
    score_d = score_q;
    if (zera_s) begin
      // Clear wins over a coincident increment, including the score bump of a wrap.
      cnt_d   = '0;
      score_d = '0;
    end else if (inc) begin
      if (cnt_q == QLast) begin
        cnt_d = '0;
        if (score_q < SLast) begin
          score_d = score_q + NMAX'(1);
        end
      end else begin
        cnt_d = cnt_q + N'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      score_q <= '0;
    end else begin
      prev_q  <= sinal;
      cnt_q   <= cnt_d;
      score_q <= score_d;
    end
  end

  assign Q        = cnt_q;
  assign fim      = (cnt_q == QLast);
  assign meio     = (cnt_q == QHalf);
  assign Q_max    = score_q;
  assign fim_max  = (score_q == SLast);
  assign meio_max = (score_q == SHalf);

endmodule

// File: tb/tb_counter_edge_unit.sv
// Scoreboard bench for counter_edge_unit (M=5, MAX=3): each issued pulse queues the
// counter state expected while pulso is high; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_counter_edge_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       sinal, conta, zera_s;
  logic       pulso, fim, meio, fim_max, meio_max;
  logic [2:0] Q;
  logic [1:0] Q_max;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  counter_edge_unit #(.M(5), .N(3), .MAX(3), .NMAX(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .sinal    (sinal),
    .conta    (conta),
    .zera_s   (zera_s),
    .pulso    (pulso),
    .Q        (Q),
    .fim      (fim),
    .meio     (meio),
    .Q_max    (Q_max),
    .fim_max  (fim_max),
    .meio_max (meio_max)
  );

  always #5 clock = ~clock;

  // Packed view {Q, fim, meio, Q_max, fim_max, meio_max}; decodes hand-written for M=5, MAX=3.
  function automatic logic [8:0] mk(input int q, input int qm);
    mk = {3'(q), q == 4, q == 2, 2'(qm), qm == 3, qm == 1};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Monitor: every cycle with pulso high must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && pulso === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulso=1 Q=%0d Q_max=%0d, expected no pulse",
                 Q, Q_max);
      end else begin
        chk("pulse_state", {Q, fim, meio, Q_max, fim_max, meio_max}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_pulse(input logic c, input logic z, input int q, input int qm);
    exp_q.push_back(mk(q, qm));
    sinal  = 1'b1;
    conta  = c;
    zera_s = z;
    step();
    sinal  = 1'b0;
    conta  = 1'b1;
    zera_s = 1'b0;
    step();
  endtask

  task automatic clear();
    zera_s = 1'b1;
    step();
    zera_s = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sinal = 1'b1; conta = 1'b1; zera_s = 1'b0;
    repeat (3) step();
    // In reset with sinal high: counters zero, pulso follows sinal.
    chk("reset_state", {Q, fim, meio, Q_max, fim_max, meio_max}, mk(0, 0));
    chk("reset_pulso", {8'd0, pulso}, 9'd1);

    // Release with sinal held high for 10 cycles: exactly one pulse, Q goes to 1.
    exp_q.push_back(mk(0, 0));
    reset = 1'b1;
    repeat (10) step();
    sinal = 1'b0;
    step();

    // conta low: pulse seen, Q stays 1.
    do_pulse(1'b0, 1'b0, 1, 0);
    do_pulse(1'b0, 1'b0, 1, 0);
    clear();
    chk("after_clear", {Q, fim, meio, Q_max, fim_max, meio_max}, mk(0, 0));

    // 20 pulses: Q cycles 0..4, score 0,1,2,3 then saturates.
    for (int i = 0; i < 20; i++) do_pulse(1'b1, 1'b0, i % 5, (i / 5 > 3) ? 3 : i / 5);
    for (int i = 0; i < 4; i++) do_pulse(1'b1, 1'b0, i, 3);
    // Clear coincident with a wrapping pulse at Q=4: both counters go to 0.
    do_pulse(1'b1, 1'b1, 4, 3);
    do_pulse(1'b1, 1'b0, 0, 0);
    do_pulse(1'b0, 1'b0, 1, 0);

    // Reach Q=3, Q_max=2, then assert reset between clock edges.
    clear();
    for (int i = 0; i < 13; i++) do_pulse(1'b1, 1'b0, i % 5, i / 5);
    do_pulse(1'b0, 1'b0, 3, 2);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {Q, fim, meio, Q_max, fim_max, meio_max}, mk(0, 0));
    step();
    step();
    reset = 1'b1;
    step();
    do_pulse(1'b1, 1'b0, 0, 0);
    do_pulse(1'b0, 1'b0, 1, 0);

    repeat (3) step();
    chk("queue_drained", 9'(exp_q.size()), 9'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
